// File: rtl/instr_issue_unit_pkg.sv
// Shared definitions for the instruction issue front-end and the execution FSMs:
// state encoding, opcode constants, done-flag indices and instruction field positions.
package instr_issue_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_MEM = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_EXEC     = 3'd4,
    ST_HALT     = 3'd5,
    ST_ERROR    = 3'd6
  } state_t;

  // Opcode map; everything from 4'h0 up to OP_ALU_HI is an ALU operation.
  localparam logic [3:0] OP_ALU_HI  = 4'h7;
  localparam logic [3:0] OP_MOVE    = 4'h8;
  localparam logic [3:0] OP_MOVI    = 4'h9;
  localparam logic [3:0] OP_ALUI_LO = 4'hA;
  localparam logic [3:0] OP_ALUI_HI = 4'hC;
  localparam logic [3:0] OP_STORE   = 4'hD;
  localparam logic [3:0] OP_LOAD    = 4'hE;
  localparam logic [3:0] OP_HALT    = 4'hF;

  // Bit positions inside the fsm_done vector.
  localparam logic [2:0] DONE_ALU   = 3'd0;
  localparam logic [2:0] DONE_MOVE  = 3'd1;
  localparam logic [2:0] DONE_ALUI  = 3'd2;
  localparam logic [2:0] DONE_MOVI  = 3'd3;
  localparam logic [2:0] DONE_STORE = 3'd4;
  localparam logic [2:0] DONE_LOAD  = 3'd5;

  // Instruction word layout: opcode | param1 | param2.
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int P1_MSB     = 11;
  localparam int P1_LSB     = 6;
  localparam int P2_MSB     = 5;
  localparam int P2_LSB     = 0;

  // Which fsm_done bit retires an instruction of the given opcode.
  function automatic logic [2:0] done_index(input logic [3:0] op);
    logic [2:0] idx;
    idx = DONE_ALU;
    if (op <= OP_ALU_HI)                          idx = DONE_ALU;
    else if (op == OP_MOVE)                       idx = DONE_MOVE;
    else if (op == OP_MOVI)                       idx = DONE_MOVI;
    else if (op >= OP_ALUI_LO && op <= OP_ALUI_HI) idx = DONE_ALUI;
    else if (op == OP_STORE)                      idx = DONE_STORE;
    else if (op == OP_LOAD)                       idx = DONE_LOAD;
    return idx;
  endfunction

endpackage

// File: rtl/instr_issue_unit_decode.sv
// Combinational split of a 16-bit instruction into its fields plus the index of
// the fsm_done bit that completes it. Shared with the execution FSMs.
module instr_field_decode
  import instr_issue_unit_pkg::*;
(
  input  logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic [5:0]  param1,
  output logic [5:0]  param2,
  output logic [2:0]  done_sel,
  output logic        is_halt
);

  assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
  assign param1 = instr[P1_MSB:P1_LSB];
  assign param2 = instr[P2_MSB:P2_LSB];

  // Class select and halt detection from the opcode field.
  always_comb begin
    done_sel = done_index(opcode);
    is_halt  = (opcode == OP_HALT);
  end

endmodule

// File: rtl/instr_issue_unit.sv
// Instruction issue front-end: fetch from a 1-cycle-latency memory, decode,
// launch the execution FSM with a one-cycle start code, wait for its done,
// then advance. HALT and execution timeout are terminal until reset.
module instr_issue_unit
  import instr_issue_unit_pkg::*;
#(
  parameter int         ADDR_WIDTH = 8,
  parameter int         TIMEOUT    = 64,
  parameter logic [3:0] START_CODE = 4'b1111
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  output logic                  instr_rd_en,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic [15:0]           instr_data,
  output logic [3:0]            opcode,
  output logic [5:0]            param1,
  output logic [5:0]            param2,
  output logic [3:0]            FSM_start,
  input  logic [5:0]            fsm_done,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [15:0]           retired_count,
  output logic                  busy,
  output logic                  halted,
  output logic                  error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, next_state;
  logic [15:0]       instr_q;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [CNT_W-1:0]  tmo_next;
  logic [2:0]        done_sel;
  logic              is_halt;
  logic              done_hit;
  logic              tmo_hit;
  logic              retire;

  instr_field_decode u_decode (
    .instr    (instr_q),
    .opcode   (opcode),
    .param1   (param1),
    .param2   (param2),
    .done_sel (done_sel),
    .is_halt  (is_halt)
  );

  assign instr_addr = pc;
  assign done_hit   = fsm_done[done_sel];
  assign tmo_next   = tmo_cnt + CNT_W'(1);
  assign tmo_hit    = (tmo_next == CNT_W'(TIMEOUT));
  // A done in the same cycle as the timeout wins.
  assign retire     = (state == ST_EXEC) && done_hit;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic and per-state control outputs.
  always_comb begin
    next_state  = state;
    instr_rd_en = 1'b0;
    FSM_start   = 4'b0000;
    busy        = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (run) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        instr_rd_en = 1'b1;
        next_state  = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: next_state = ST_ISSUE;
      ST_ISSUE: begin
        if (is_halt) begin
          next_state = ST_HALT;
        end else begin
          FSM_start  = START_CODE;
          next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (done_hit)     next_state = run ? ST_FETCH : ST_IDLE;
        else if (tmo_hit) next_state = ST_ERROR;
      end
      ST_HALT:  busy = 1'b0;
      ST_ERROR: busy = 1'b0;
      default: begin
        busy       = 1'b0;
        next_state = ST_IDLE;
      end
    endcase
  end

  // Instruction latch, timeout counter, PC, retirement count and sticky flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      instr_q       <= '0;
      tmo_cnt       <= '0;
      pc            <= '0;
      retired_count <= '0;
      halted        <= 1'b0;
      error         <= 1'b0;
    end else begin
      if (state == ST_WAIT_MEM) instr_q <= instr_data;
      if (state == ST_ISSUE)     tmo_cnt <= '0;
      else if (state == ST_EXEC) tmo_cnt <= tmo_next;
      if (retire) begin
        pc <= pc + ADDR_WIDTH'(1);
        if (retired_count != 16'hFFFF) retired_count <= retired_count + 16'd1;
      end
      if (state == ST_ISSUE && is_halt) halted <= 1'b1;
      if (state == ST_EXEC && !done_hit && tmo_hit) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit: reset, single ALU, class filtering,
// HALT, timeout (with and without a last-cycle done), PC wrap and mid-EXEC reset.
module tb_instr_issue_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run   = 1'b0;
  logic [5:0]  fsm_done = 6'b0;

  // Main instance, ADDR_WIDTH = 8
  logic        rd_en;
  logic [7:0]  addr;
  logic [15:0] data;
  logic [3:0]  opcode, fsm_start;
  logic [5:0]  param1, param2;
  logic [7:0]  pc;
  logic [15:0] retired;
  logic        busy, halted, error;
  logic [15:0] mem0 [256];

  // Wrap instance, ADDR_WIDTH = 2
  logic        rd_en2;
  logic [1:0]  addr2;
  logic [15:0] data2;
  logic [3:0]  opcode2, fsm_start2;
  logic [5:0]  param1_2, param2_2;
  logic [1:0]  pc2;
  logic [15:0] retired2;
  logic        busy2, halted2, error2;
  logic [15:0] mem2 [4];

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int start_snap;

  always #5 clock = ~clock;

  instr_issue_unit #(.ADDR_WIDTH(8), .TIMEOUT(64), .START_CODE(4'b1111)) dut (
    .clock(clock), .reset(reset), .run(run), .instr_rd_en(rd_en), .instr_addr(addr),
    .instr_data(data), .opcode(opcode), .param1(param1), .param2(param2),
    .FSM_start(fsm_start), .fsm_done(fsm_done), .pc(pc), .retired_count(retired),
    .busy(busy), .halted(halted), .error(error)
  );

  instr_issue_unit #(.ADDR_WIDTH(2), .TIMEOUT(64), .START_CODE(4'b1111)) dut2 (
    .clock(clock), .reset(reset), .run(run), .instr_rd_en(rd_en2), .instr_addr(addr2),
    .instr_data(data2), .opcode(opcode2), .param1(param1_2), .param2(param2_2),
    .FSM_start(fsm_start2), .fsm_done(fsm_done), .pc(pc2), .retired_count(retired2),
    .busy(busy2), .halted(halted2), .error(error2)
  );

  // Instruction memories with one cycle of read latency.
  always @(posedge clock) begin
    if (rd_en)  data  <= mem0[addr];
    if (rd_en2) data2 <= mem2[addr2];
  end

  // Count start pulses of the main instance.
  always @(posedge clock) begin
    if (fsm_start != 4'b0000) start_cnt = start_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run   = 1'b0;
    fsm_done = 6'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // From IDLE with run=1: FETCH, WAIT_MEM, then sit in ISSUE.
  task automatic to_issue();
    run = 1'b1;
    tick();
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem0[i] = 16'h0000;
    for (int i = 0; i < 4; i++) mem2[i] = 16'h0000;

    // Reset held two cycles with run=1
    run = 1'b1;
    tick();
    tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_pc", {24'b0, pc}, 32'd0);
    check("rst_retired", {16'b0, retired}, 32'd0);
    check("rst_start", {28'b0, fsm_start}, 32'd0);
    check("rst_flags", {29'b0, rd_en, halted, error}, 32'd0);
    check("rst_fields", {16'b0, opcode, param1, param2}, 32'd0);

    // Single ALU instruction, done 3 cycles after the start pulse
    mem0[0] = 16'h1041;
    do_reset();
    run = 1'b1;
    tick();
    check("alu_fetch", {23'b0, rd_en, addr}, {23'b0, 1'b1, 8'd0});
    tick();
    tick();
    start_snap = start_cnt;
    check("alu_issue_start", {28'b0, fsm_start}, 32'hF);
    check("alu_fields", {16'b0, opcode, param1, param2}, {16'b0, 4'h1, 6'd1, 6'd1});
    tick();
    check("alu_exec_start", {28'b0, fsm_start}, 32'd0);
    check("alu_exec_hold", {16'b0, opcode, param1, param2}, {16'b0, 4'h1, 6'd1, 6'd1});
    tick();
    tick();
    fsm_done = 6'b000001;
    run = 1'b0;
    tick();
    fsm_done = 6'b0;
    check("alu_pc", {24'b0, pc}, 32'd1);
    check("alu_retired", {16'b0, retired}, 32'd1);
    check("alu_idle", {31'b0, busy}, 32'd0);
    check("alu_one_start", start_cnt - start_snap, 32'd1);

    // Class filtering: STORE ignores ALU done
    mem0[0] = 16'hD000;
    do_reset();
    to_issue();
    tick();
    fsm_done = 6'b000001;
    tick();
    fsm_done = 6'b0;
    check("store_ign_ret", {16'b0, retired}, 32'd0);
    check("store_ign_busy", {31'b0, busy}, 32'd1);
    tick();
    fsm_done = 6'b010000;
    run = 1'b0;
    tick();
    fsm_done = 6'b0;
    check("store_ret", {16'b0, retired}, 32'd1);
    check("store_pc", {24'b0, pc}, 32'd1);

    // HALT after one MOVE
    mem0[0] = 16'h8000;
    mem0[1] = 16'hF000;
    do_reset();
    to_issue();
    start_snap = start_cnt;
    tick();
    fsm_done = 6'b000010;
    tick();
    fsm_done = 6'b0;
    tick();
    tick();
    check("halt_issue_start", {28'b0, fsm_start}, 32'd0);
    tick();
    check("halt_flag", {31'b0, halted}, 32'd1);
    check("halt_busy", {31'b0, busy}, 32'd0);
    check("halt_pc", {24'b0, pc}, 32'd1);
    check("halt_retired", {16'b0, retired}, 32'd1);
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    tick();
    tick();
    check("halt_sticky", {29'b0, halted, busy, rd_en}, {29'b0, 3'b100});
    check("halt_pc_after", {24'b0, pc}, 32'd1);
    check("halt_starts", start_cnt - start_snap, 32'd1);

    // Timeout with no done
    mem0[0] = 16'h0000;
    do_reset();
    to_issue();
    tick();
    for (int i = 0; i < 63; i++) tick();
    check("tmo_cyc64_busy", {30'b0, busy, error}, {30'b0, 2'b10});
    tick();
    check("tmo_error", {31'b0, error}, 32'd1);
    check("tmo_busy", {31'b0, busy}, 32'd0);
    check("tmo_retired", {16'b0, retired}, 32'd0);
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    check("tmo_sticky", {30'b0, error, busy}, {30'b0, 2'b10});

    // Done in ISSUE is ignored; done in EXEC cycle 64 beats the timeout
    do_reset();
    to_issue();
    fsm_done = 6'b000001;
    tick();
    fsm_done = 6'b0;
    check("issue_done_ign", {15'b0, busy, retired}, {15'b0, 1'b1, 16'd0});
    for (int i = 0; i < 63; i++) tick();
    fsm_done = 6'b000001;
    run = 1'b0;
    tick();
    fsm_done = 6'b0;
    check("tmo_race_err", {31'b0, error}, 32'd0);
    check("tmo_race_ret", {16'b0, retired}, 32'd1);
    check("tmo_race_pc", {24'b0, pc}, 32'd1);

    // PC wrap on the 2-bit instance, then reset mid-EXEC
    mem2[0] = 16'h1041;
    mem2[1] = 16'h2000;
    mem2[2] = 16'h3000;
    mem2[3] = 16'h7FFF;
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
      tick();
      fsm_done = 6'b000001;
      tick();
      fsm_done = 6'b0;
      check("wrap_pc", {30'b0, pc2}, (i + 1) % 4);
      check("wrap_ret", {16'b0, retired2}, i + 1);
    end
    check("wrap_last_op", {16'b0, opcode2, param1_2, param2_2}, {16'b0, 16'h7FFF});
    tick();
    tick();
    tick();
    check("mid_exec_busy", {31'b0, busy2}, 32'd1);
    reset = 1'b0;
    tick();
    check("mid_rst_pc", {30'b0, pc2}, 32'd0);
    check("mid_rst_ret", {16'b0, retired2}, 32'd0);
    check("mid_rst_busy", {31'b0, busy2}, 32'd0);
    reset = 1'b1;
    run = 1'b0;
    fsm_done = 6'b000001;
    tick();
    fsm_done = 6'b0;
    check("late_done_ret", {16'b0, retired2}, 32'd0);
    check("late_done_pc", {30'b0, pc2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
